// File: rtl/instr_exec_unit_if.sv
// rtl/instr_exec_unit_if.sv - instruction read port and result channel of instr_exec_unit
interface instr_exec_unit_if #(
   parameter int DEPTH = 32
);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]      read_pointer;
   logic [67:0]        instruction_word;
   logic               res_valid;
   logic               res_ready;
   logic signed [63:0] result;
   logic [3:0]         res_opcode;
   logic [PW-1:0]      res_ptr;
   logic               res_err;

   modport master (
      output read_pointer,
      input  instruction_word,
      output res_valid,
      input  res_ready,
      output result,
      output res_opcode,
      output res_ptr,
      output res_err
   );

   modport slave (
      input  read_pointer,
      output instruction_word,
      input  res_valid,
      output res_ready,
      input  result,
      input  res_opcode,
      input  res_ptr,
      input  res_err
   );
endinterface

// File: rtl/instr_exec_unit.sv
// rtl/instr_exec_unit.sv - walks instruction slots, evaluates each with a signed ALU
// Define INSTR_EXEC_DIV_EN to build the divider; otherwise DIV/MOD report as illegal.
module instr_exec_unit #(
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [$clog2(DEPTH)-1:0]   first_ptr,
   input  logic [$clog2(DEPTH):0]     count,
   output logic                       busy,
   output logic                       done,
   instr_exec_unit_if.master          bus
);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, RESP, DONE} state_t;
   typedef enum logic [3:0] {
      OP_ZERO = 4'd0, OP_PASSA = 4'd1, OP_PASSB = 4'd2, OP_ADD = 4'd3,
      OP_SUB  = 4'd4, OP_MULT  = 4'd5, OP_DIV   = 4'd6, OP_MOD = 4'd7
   } opcode_t;

   state_t             state, state_nx;
   logic [PW:0]        remaining;
   logic [67:0]        instr_q;
   logic signed [63:0] op_a, op_b, alu_res;
   logic               alu_err;

   assign op_a = {{32{instr_q[63]}}, instr_q[63:32]};
   assign op_b = {{32{instr_q[31]}}, instr_q[31:0]};

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (instr_q[67:64])
         OP_ZERO:  alu_res = '0;
         OP_PASSA: alu_res = op_a;
         OP_PASSB: alu_res = op_b;
         OP_ADD:   alu_res = op_a + op_b;
         OP_SUB:   alu_res = op_a - op_b;
         OP_MULT:  alu_res = op_a * op_b;
`ifdef INSTR_EXEC_DIV_EN
         OP_DIV:   if (op_b == 0) alu_err = 1'b1; else alu_res = op_a / op_b;
         OP_MOD:   if (op_b == 0) alu_err = 1'b1; else alu_res = op_a % op_b;
`endif
         default:  alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = (count == 0) ? DONE : FETCH;
         FETCH: state_nx = EXEC;
         EXEC:  state_nx = RESP;
         RESP:  if (bus.res_ready) state_nx = (remaining == 1) ? DONE : FETCH;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bus.read_pointer <= '0;
         remaining        <= '0;
         instr_q          <= '0;
         bus.result       <= '0;
         bus.res_opcode   <= '0;
         bus.res_ptr      <= '0;
         bus.res_err      <= 1'b0;
         bus.res_valid    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               bus.read_pointer <= first_ptr;
               remaining        <= count;
            end
            FETCH: instr_q <= bus.instruction_word;
            EXEC: begin
               bus.result     <= alu_res;
               bus.res_opcode <= instr_q[67:64];
               bus.res_ptr    <= bus.read_pointer;
               bus.res_err    <= alu_err;
               bus.res_valid  <= 1'b1;
            end
            RESP: if (bus.res_ready) begin
               bus.res_valid    <= 1'b0;
               // slot index wraps at DEPTH even when DEPTH is not a power of two
               bus.read_pointer <= (bus.read_pointer == PW'(DEPTH - 1)) ? '0
                                                                         : bus.read_pointer + 1'b1;
               remaining        <= remaining - 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
